// File: rtl/data_mem_if.sv
// data_mem_if: valid/ready request bus between the MEM stage and data_mem_ctrl.
interface data_mem_if;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;
    modport master (
        output req_valid, req_write, req_size, req_unsigned, addr, wdata,
        input  ready, rdata, rvalid, err
    );
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, addr, wdata,
        output ready, rdata, rvalid, err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: big-endian byte-addressed data memory with registered loads, error reporting and init sweep.
module data_mem_ctrl #(
    parameter int DEPTH      = 1024,
    parameter int WATCH_BASE = 16,
    parameter int INIT_CLEAR = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    data_mem_if.slave   bus,
    output logic [31:0] watch_word
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = AW - 2;
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [7:0]    mem [DEPTH];
    logic [0:0]    state;
    logic [WW-1:0] widx;
    logic          acc, bad, clearing;
    logic [2:0]    nb;
    logic [32:0]   last;
    logic [AW-1:0] a0, a1, a2, a3;
    logic [7:0]    b0, b1, b2, b3;
    logic          sx;
    logic [31:0]   ld;

    assign bus.ready = state == RUN;
    assign acc       = bus.req_valid && bus.ready;
    assign clearing  = INIT_CLEAR != 0 && state == INIT;
    assign nb        = bus.req_size == 2'b10 ? 3'd4 : bus.req_size == 2'b01 ? 3'd2 : 3'd1;
    // Range check on the full 33-bit sum so high addresses cannot wrap into the array.
    assign last      = {1'b0, bus.addr} + 33'(nb) - 33'd1;
    assign bad       = bus.req_size == 2'b11
                    || (bus.req_size == 2'b01 && bus.addr[0])
                    || (bus.req_size == 2'b10 && bus.addr[1:0] != 2'b00)
                    || last >= 33'(DEPTH);

    assign a0 = bus.addr[AW-1:0];
    assign a1 = a0 + AW'(1);
    assign a2 = a0 + AW'(2);
    assign a3 = a0 + AW'(3);
    assign b0 = mem[a0];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];
    assign sx = ~bus.req_unsigned & b0[7];
    assign ld = bus.req_size == 2'b10 ? {b0, b1, b2, b3}
              : bus.req_size == 2'b01 ? {{16{sx}}, b0, b1}
              : {{24{sx}}, b0};

    assign watch_word = {mem[WATCH_BASE], mem[WATCH_BASE+1], mem[WATCH_BASE+2], mem[WATCH_BASE+3]};

    always_ff @(posedge clk) begin
        if (clearing) begin
            for (int k = 0; k < 4; k++)
                mem[{widx, 2'(k)}] <= '0;
        end else if (acc && bus.req_write && !bad) begin
            if (bus.req_size == 2'b10) begin
                mem[a0] <= bus.wdata[31:24];
                mem[a1] <= bus.wdata[23:16];
                mem[a2] <= bus.wdata[15:8];
                mem[a3] <= bus.wdata[7:0];
            end else if (bus.req_size == 2'b01) begin
                mem[a0] <= bus.wdata[15:8];
                mem[a1] <= bus.wdata[7:0];
            end else begin
                mem[a0] <= bus.wdata[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= INIT;
            widx       <= '0;
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            if (state == INIT) begin
                widx <= widx + WW'(1);
                if (INIT_CLEAR == 0 || widx == '1)
                    state <= RUN;
            end
            bus.rvalid <= acc && !bus.req_write;
            bus.err    <= acc && bad;
            if (acc && !bus.req_write)
                bus.rdata <= bad ? '0 : ld;
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized and directed checks of data_mem_ctrl against a byte-array model.
module tb_data_mem_ctrl;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] watch_word;
    data_mem_if  bus();

    data_mem_ctrl #(.DEPTH(DEPTH), .WATCH_BASE(16), .INIT_CLEAR(1)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .watch_word(watch_word)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  model [DEPTH];
    logic [31:0] exp_rdata;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(logic [1:0] sz);
        return sz == 2'b10 ? 4 : sz == 2'b01 ? 2 : 1;
    endfunction

    function automatic bit rejected(logic [1:0] sz, logic [31:0] a);
        longint la;
        la = longint'({32'b0, a});
        if (sz == 2'b11) return 1'b1;
        if (la % nbytes(sz) != 0) return 1'b1;
        return la + nbytes(sz) - 1 >= DEPTH;
    endfunction

    function automatic logic [31:0] model_watch();
        return {model[16], model[17], model[18], model[19]};
    endfunction

    task automatic step(bit v, bit w, logic [1:0] sz, bit u, logic [31:0] a, logic [31:0] d);
        bit     bad, exp_rv;
        int     n;
        longint val;
        n      = nbytes(sz);
        bad    = v && rejected(sz, a);
        exp_rv = v && !w;
        bus.req_valid    = v;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.addr         = a;
        bus.wdata        = d;
        if (exp_rv) begin
            if (bad) exp_rdata = '0;
            else begin
                val = 0;
                for (int i = 0; i < n; i++) val = (val << 8) | longint'(model[int'(a) + i]);
                if (!u && val[8*n-1]) val = val - (longint'(1) << (8 * n));
                exp_rdata = val[31:0];
            end
        end
        if (v && w && !bad)
            for (int i = 0; i < n; i++) model[int'(a) + i] = 8'(d >> (8 * (n - 1 - i)));
        @(posedge clk);
        #1;
        check("rvalid", 32'(bus.rvalid), 32'(exp_rv));
        check("err", 32'(bus.err), 32'(bad));
        check("rdata", bus.rdata, exp_rdata);
        check("watch", watch_word, model_watch());
        bus.req_valid = 1'b0;
    endtask

    task automatic sweep(string tag);
        int n;
        check({tag, "_ready_low"}, 32'(bus.ready), 32'd0);
        reset_n = 1'b1;
        for (n = 1; n <= 2000; n++) begin
            @(posedge clk);
            #1;
            if (bus.ready) break;
        end
        check(tag, n, 256);
        foreach (model[i]) model[i] = 8'h00;
    endtask

    initial begin
        logic [31:0] ra;
        int          pick;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.addr = '0; bus.wdata = '0;
        exp_rdata = '0;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.ready), 0);
        check("rst_rvalid", 32'(bus.rvalid), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_rdata", bus.rdata, 0);
        sweep("init_len");

        step(1, 0, 2'b10, 0, 32'h3FC, 0);
        check("ld_3fc", bus.rdata, 32'h0);
        step(1, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
        check("watch_dead", watch_word, 32'hDEADBEEF);
        step(1, 0, 2'b10, 0, 32'h10, 0);
        check("ld_w10", bus.rdata, 32'hDEADBEEF);
        step(1, 0, 2'b00, 0, 32'h11, 0);
        check("ld_sb11", bus.rdata, 32'hFFFFFFAD);
        step(1, 0, 2'b01, 1, 32'h12, 0);
        check("ld_uh12", bus.rdata, 32'h0000BEEF);
        step(1, 1, 2'b00, 0, 32'h13, 32'h80);
        step(1, 1, 2'b01, 0, 32'h10, 32'h1234);
        step(1, 0, 2'b10, 0, 32'h10, 0);
        check("ld_mix", bus.rdata, 32'h1234BE80);
        step(0, 0, 2'b00, 0, 0, 0);
        check("rvalid_pulse", 32'(bus.rvalid), 0);

        step(1, 1, 2'b01, 0, 32'h21, 32'hFFFF);
        check("err_h21", 32'(bus.err), 1);
        step(1, 0, 2'b10, 0, 32'h20, 0);
        check("mem_untouched", bus.rdata, 0);
        step(1, 0, 2'b10, 0, 32'h3FE, 0);
        check("err_3fe", 32'(bus.err), 1);
        step(1, 0, 2'b11, 0, 32'h40, 0);
        check("err_size3", 32'(bus.err), 1);
        step(1, 0, 2'b10, 0, 32'hFFFFFFFC, 0);
        check("err_wrap", 32'(bus.err), 1);

        for (int t = 0; t < 1500; t++) begin
            pick = int'($urandom_range(0, 9));
            ra = pick == 0 ? $urandom
               : pick < 4 ? $urandom_range(DEPTH - 8, DEPTH + 3)
               : pick < 7 ? $urandom_range(0, 31)
               : $urandom_range(0, DEPTH - 1);
            step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, ra, $urandom);
        end

        step(1, 1, 2'b10, 0, 32'h40, 32'hCAFEF00D);
        step(1, 0, 2'b10, 0, 32'h40, 0);
        #3 reset_n = 1'b0;
        #1;
        check("arst_rdata", bus.rdata, 0);
        check("arst_rvalid", 32'(bus.rvalid), 0);
        check("arst_ready", 32'(bus.ready), 0);
        exp_rdata = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_ready", 32'(bus.ready), 0);
        check("mid_rdata", bus.rdata, 0);
        @(posedge clk);
        #1;
        sweep("resweep_len");
        check("watch_clear", watch_word, 0);
        step(1, 0, 2'b10, 0, 32'h40, 0);
        check("ld_40_clear", bus.rdata, 0);
        step(1, 0, 2'b10, 0, 32'h3FC, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised byte-addressed, big-endian data memory with a valid/ready request interface for the MEM stage.
- Supports byte, halfword and word loads and stores; loads are signed or unsigned.
- Read data is registered: one-cycle latency, marked by an rvalid pulse.
- Misaligned or out-of-range accesses are detected and reported as errors instead of corrupting memory.
- After reset, an init sweep clears the array, and a parametrised watch window exposes one word for debug/display.

Parameters:
DEPTH, 1024, memory size in bytes; power of 2, minimum 8.
WATCH_BASE, 16, byte address of the word driven on watch_word; multiple of 4, less than DEPTH.
INIT_CLEAR, 1, 1 = zero the array after reset; 0 = skip the sweep.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_write  input  1  1 = store, 0 = load.
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
addr  input  32  byte address of the access (full 32 bits are checked).
wdata  input  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
ready  output  1  block can accept a request this cycle.
rdata  output  32  load result, registered.
rvalid  output  1  one-cycle pulse: rdata is valid.
err  output  1  one-cycle pulse: the previously accepted request was rejected.
watch_word  output  32  {mem[WATCH_BASE], mem[WATCH_BASE+1], mem[WATCH_BASE+2], mem[WATCH_BASE+3]}, combinational.

Behaviour:
- Reset (reset_n low, asynchronous): ready=0, rvalid=0, err=0, rdata=0. Init counter and state are cleared. Array contents are not reset directly.
- FSM states: INIT, RUN.
  - Reset release with INIT_CLEAR=1: enter INIT. Each cycle one aligned word is zeroed, at word index 0..DEPTH/4-1. After the last word, go to RUN. INIT lasts exactly DEPTH/4 cycles.
  - INIT_CLEAR=0: go to RUN on the first clock edge after reset release.
- ready = 1 only in RUN. A request is accepted on an edge where req_valid && ready. One request per cycle; no internal backpressure in RUN.
- Reset asserted mid-INIT aborts the sweep; the sweep restarts from index 0 after release.
- A request is rejected (err=1 on the next cycle, memory untouched) when any of these hold:
  - req_size=11;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr+bytes-1 >= DEPTH, evaluated on the full 32-bit addr with no wrap-around.
- Rejected load: rvalid=1 with rdata=0 on the same cycle as err. Rejected store: err only.
- Store byte placement (big-endian), written on the accepting edge:
  - word: mem[a]=wdata[31:24], mem[a+1]=wdata[23:16], mem[a+2]=wdata[15:8], mem[a+3]=wdata[7:0];
  - halfword: mem[a]=wdata[15:8], mem[a+1]=wdata[7:0];
  - byte: mem[a]=wdata[7:0].
- Load: on the accepting edge, rdata is assembled big-endian from the bytes at a, then sign- or zero-extended to 32 bits. rvalid=1 in the following cycle. rdata holds its value until the next load completes.
- Store then load to the same address in the next cycle returns the new data; the store is committed at its edge.
- rvalid and err are deasserted in every cycle with no completion.
- watch_word tracks array contents combinationally, including during INIT clearing.

Test Plan:
- Init sweep, DEPTH=1024, INIT_CLEAR=1: release reset -> ready low for exactly 256 cycles, then high; a word load of 0x3FC returns 0x00000000.
- Word store 0xDEADBEEF to 0x10, then loads -> word load returns 0xDEADBEEF; watch_word=0xDEADBEEF; signed byte load at 0x11 returns 0xFFFFFFAD; unsigned halfword load at 0x12 returns 0x0000BEEF.
- Byte store 0x80 to 0x13 and halfword store 0x1234 to 0x10 in back-to-back cycles, then word load of 0x10 -> 0x1234BE80, with rvalid exactly 1 cycle after acceptance.
- Error cases:
  - halfword store to 0x21 -> err pulse, memory unchanged;
  - word load at 0x3FE -> err and rvalid with rdata=0;
  - req_size=11 -> err;
  - addr=0xFFFFFFFC word load -> err (no wrap-around).
- Assert reset_n for 1 cycle at INIT cycle 100 -> outputs cleared immediately; a new sweep of 256 cycles follows release.
- Randomised back-to-back mixed loads and stores, 1 per cycle, checked against a byte-array model -> rdata, rvalid and err match every cycle.
